// File: rtl/vxe_traffic_gen_pkg.sv
// vxe_traffic_gen_pkg: types and constants shared by the VxE traffic generator files.
// Optional feature macro: VXE_TGEN_ERR_INJ_EN (periodic error-status injection on the top).
package vxe_traffic_gen_pkg;

   // Width of the issued-response counter exported on o_nresp.
   localparam int NRESP_W = 16;

   // What the output stage loads when a queued request is launched.
   typedef enum logic [1:0] {
      RESP_IMAGE = 2'd0,
      RESP_TERM  = 2'd1,
      RESP_ERR   = 2'd2
   } resp_kind_e;

   // Queue pointers carry one extra wrap bit so full and empty are distinguishable.
   function automatic int qPtrWidth(input int depthPow2);
      return depthPow2 + 1;
   endfunction

endpackage

// File: rtl/vxe_tgen_tsq.sv
// vxe_tgen_tsq: in-order queue of request-accept timestamps for the traffic generator.
// The head entry's timestamp decides when the oldest outstanding request may be answered.
module vxe_tgen_tsq
   import vxe_traffic_gen_pkg::*;
#(
   parameter int TSW        = 8,
   parameter int DEPTH_POW2 = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr_i,
   input  logic           push_i,
   input  logic [TSW-1:0] pushTs_i,
   input  logic           pop_i,
   output logic [TSW-1:0] headTs_o,
   output logic           full_o,
   output logic           empty_o
);

   localparam int DEPTH = 1 << DEPTH_POW2;
   localparam int PW    = qPtrWidth(DEPTH_POW2);

   logic [TSW-1:0]        mem_q [DEPTH];
   logic [PW-1:0]         wrPtr_q, wrPtr_d;
   logic [PW-1:0]         rdPtr_q, rdPtr_d;
   logic [DEPTH_POW2-1:0] wrAddr, rdAddr;
   logic                  doPush, doPop;

   assign wrAddr   = wrPtr_q[DEPTH_POW2-1:0];
   assign rdAddr   = rdPtr_q[DEPTH_POW2-1:0];
   assign empty_o  = (wrPtr_q == rdPtr_q);
   assign full_o   = (wrPtr_q[PW-1] != rdPtr_q[PW-1]) && (wrAddr == rdAddr);
   assign headTs_o = mem_q[rdAddr];
   assign doPush   = push_i & ~full_o;
   assign doPop    = pop_i & ~empty_o;

   // Advance each pointer independently; a simultaneous push and pop leaves occupancy unchanged.
   always_comb begin
      wrPtr_d = wrPtr_q + PW'(doPush);
      rdPtr_d = rdPtr_q + PW'(doPop);
   end

   // Pointer registers; a soft clear empties the queue exactly like reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else if (clr_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   // Timestamp storage needs no reset since empty entries are never read as valid.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrAddr] <= pushTs_i;
      end
   end

endmodule

// File: rtl/vxe_traffic_gen.sv
// vxe_traffic_gen: memory-responder model for VxE unit benches. Pops requests from a show-ahead
// request FIFO, answers them in order from an external command image after a fixed latency.
// Optional feature macro: VXE_TGEN_ERR_INJ_EN adds i_err_n / i_err_code error injection.
module vxe_traffic_gen
   import vxe_traffic_gen_pkg::*;
#(
   parameter int RQ_WIDTH   = 44,
   parameter int RS_WIDTH   = 9,
   parameter int RD_WIDTH   = 64,
   parameter int DEPTH_POW2 = 2,
   parameter int MEMIW      = 8,
   parameter int LATENCY    = 0,
   parameter int TSW        = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_clr,
   input  logic                i_rqa_vld,
   input  logic [RQ_WIDTH-1:0] i_rqa,
   output logic                o_rqa_rd,
   output logic [MEMIW-1:0]    o_mem_idx,
   input  logic [RD_WIDTH-1:0] i_mem_data,
   input  logic [RS_WIDTH-1:0] i_mem_stat,
   input  logic                i_rss_rdy,
   input  logic                i_rsd_rdy,
   output logic [RS_WIDTH-1:0] o_rss,
   output logic                o_rss_wr,
   output logic [RD_WIDTH-1:0] o_rsd,
   output logic                o_rsd_wr,
   output logic [NRESP_W-1:0]  o_nresp,
   output logic                o_idle
`ifdef VXE_TGEN_ERR_INJ_EN
   ,
   input  logic [7:0]          i_err_n,
   input  logic [RS_WIDTH-1:0] i_err_code
`endif
);

   localparam int LATW = TSW + 1;

   logic                qFull, qEmpty;
   logic                launch, xfer, slotFree, headElig;
   logic [TSW-1:0]      ts_q, ts_d, headTs, tsAge;
   logic [MEMIW-1:0]    idx_q, idx_d;
   logic [RS_WIDTH-1:0] rss_q, rss_d;
   logic [RD_WIDTH-1:0] rsd_q, rsd_d;
   logic                wr_q, wr_d;
   logic [NRESP_W-1:0]  nresp_q, nresp_d;
   resp_kind_e          respKind;
   logic                unusedRqa;
`ifdef VXE_TGEN_ERR_INJ_EN
   logic [7:0]          errCnt_q, errCnt_d, errCntInc;
   logic                errHit;
`endif

   // The request payload carries no meaning for this model; only its arrival matters.
   assign unusedRqa = ^i_rqa;

   assign o_rqa_rd = i_rqa_vld & ~qFull & ~i_clr & ~rst;
   assign xfer     = wr_q & i_rss_rdy & i_rsd_rdy;
   assign slotFree = ~wr_q | xfer;

   // Age compare is modular so a timestamp wrap during the wait cannot release the head early.
   // Written as age+1 > LATENCY so a zero latency does not turn into a constant compare.
   assign tsAge    = ts_q - headTs;
   assign headElig = ({1'b0, tsAge} + LATW'(1)) > LATW'(LATENCY);
   assign launch   = ~qEmpty & headElig & slotFree & ~i_clr;

   vxe_tgen_tsq #(
      .TSW        (TSW),
      .DEPTH_POW2 (DEPTH_POW2)
   ) uTsq (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (i_clr),
      .push_i   (o_rqa_rd),
      .pushTs_i (ts_q),
      .pop_i    (launch),
      .headTs_o (headTs),
      .full_o   (qFull),
      .empty_o  (qEmpty)
   );

`ifdef VXE_TGEN_ERR_INJ_EN
   assign errCntInc = errCnt_q + 8'd1;
   assign errHit    = (i_err_n != 8'd0) && (errCntInc == i_err_n);
`endif

   // Classify the image entry at the current index; an injected error overrides the image.
   always_comb begin
      respKind = RESP_IMAGE;
      if (&i_mem_data) begin
         respKind = RESP_TERM;
      end
`ifdef VXE_TGEN_ERR_INJ_EN
      if (errHit) begin
         respKind = RESP_ERR;
      end
`endif
   end

   // Next state of the output stage: a transfer empties the slot, a launch refills it in the same cycle.
   always_comb begin
      ts_d    = ts_q + TSW'(1);
      idx_d   = idx_q;
      rss_d   = rss_q;
      rsd_d   = rsd_q;
      wr_d    = wr_q;
      nresp_d = nresp_q;
`ifdef VXE_TGEN_ERR_INJ_EN
      errCnt_d = errCnt_q;
`endif
      if (xfer) begin
         wr_d    = 1'b0;
         nresp_d = nresp_q + NRESP_W'(1);
      end
      if (launch) begin
         wr_d = 1'b1;
         case (respKind)
            RESP_TERM: begin
               rss_d = '0;
               rsd_d = '0;
            end
`ifdef VXE_TGEN_ERR_INJ_EN
            RESP_ERR: begin
               rss_d = i_err_code;
               rsd_d = '0;
               idx_d = idx_q + MEMIW'(1);
            end
`endif
            default: begin
               rss_d = i_mem_stat;
               rsd_d = i_mem_data;
               idx_d = idx_q + MEMIW'(1);
            end
         endcase
`ifdef VXE_TGEN_ERR_INJ_EN
         if (i_err_n != 8'd0) begin
            errCnt_d = errHit ? 8'd0 : errCntInc;
         end
`endif
      end
   end

   // Registered response outputs, counters and timestamp; soft clear behaves like reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_q     <= '0;
         idx_q    <= '0;
         rss_q    <= '0;
         rsd_q    <= '0;
         wr_q     <= 1'b0;
         nresp_q  <= '0;
`ifdef VXE_TGEN_ERR_INJ_EN
         errCnt_q <= '0;
`endif
      end else if (i_clr) begin
         ts_q     <= '0;
         idx_q    <= '0;
         rss_q    <= '0;
         rsd_q    <= '0;
         wr_q     <= 1'b0;
         nresp_q  <= '0;
`ifdef VXE_TGEN_ERR_INJ_EN
         errCnt_q <= '0;
`endif
      end else begin
         ts_q     <= ts_d;
         idx_q    <= idx_d;
         rss_q    <= rss_d;
         rsd_q    <= rsd_d;
         wr_q     <= wr_d;
         nresp_q  <= nresp_d;
`ifdef VXE_TGEN_ERR_INJ_EN
         errCnt_q <= errCnt_d;
`endif
      end
   end

   assign o_mem_idx = idx_q;
   assign o_rss     = rss_q;
   assign o_rsd     = rsd_q;
   assign o_rss_wr  = wr_q;
   assign o_rsd_wr  = wr_q;
   assign o_nresp   = nresp_q;
   assign o_idle    = qEmpty & ~wr_q;

endmodule

// File: tb/tb_vxe_traffic_gen.sv
// tb_vxe_traffic_gen: directed bench for vxe_traffic_gen. Instance A runs with zero latency,
// instance B with LATENCY=5 and a 3-bit timestamp so the wait crosses the counter wrap.
// Error injection checks are built only when VXE_TGEN_ERR_INJ_EN is defined.
module tb_vxe_traffic_gen;

   typedef struct {
      logic [8:0]  memStat;
      logic [63:0] memData;
      logic [8:0]  expRss;
      logic [63:0] expRsd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  memStat [256];
   logic [63:0] memData [256];

   logic        clrA, vldA, rdA, rssRdyA, rsdRdyA, rssWrA, rsdWrA, idleA;
   logic [43:0] rqaA;
   logic [7:0]  idxA;
   logic [8:0]  rssA, statA;
   logic [63:0] rsdA, dataA;
   logic [15:0] nrespA;

   logic        clrB, vldB, rdB, rssRdyB, rsdRdyB, rssWrB, rsdWrB, idleB;
   logic [43:0] rqaB;
   logic [7:0]  idxB;
   logic [8:0]  rssB, statB;
   logic [63:0] rsdB, dataB;
   logic [15:0] nrespB;

`ifdef VXE_TGEN_ERR_INJ_EN
   logic [7:0]  errN;
   logic [8:0]  errCode;
`endif

   int          pendA = 0, accA = 0, pendB = 0, accB = 0;
   int          vecCount = 0, missCount = 0;
   logic [72:0] gotA [$];
   vec_t        flowVec [4];
   vec_t        bpVec [6];

   always #5 clk = ~clk;

   assign vldA  = (pendA != 0);
   assign vldB  = (pendB != 0);
   assign rqaA  = 44'(pendA);
   assign rqaB  = 44'(pendB);
   assign statA = memStat[idxA];
   assign dataA = memData[idxA];
   assign statB = memStat[idxB];
   assign dataB = memData[idxB];

   vxe_traffic_gen #(.LATENCY(0), .TSW(8)) dutA (
      .clk(clk), .rst(rst), .i_clr(clrA), .i_rqa_vld(vldA), .i_rqa(rqaA), .o_rqa_rd(rdA),
      .o_mem_idx(idxA), .i_mem_data(dataA), .i_mem_stat(statA), .i_rss_rdy(rssRdyA),
      .i_rsd_rdy(rsdRdyA), .o_rss(rssA), .o_rss_wr(rssWrA), .o_rsd(rsdA), .o_rsd_wr(rsdWrA),
      .o_nresp(nrespA), .o_idle(idleA)
`ifdef VXE_TGEN_ERR_INJ_EN
      , .i_err_n(errN), .i_err_code(errCode)
`endif
   );

   vxe_traffic_gen #(.LATENCY(5), .TSW(3)) dutB (
      .clk(clk), .rst(rst), .i_clr(clrB), .i_rqa_vld(vldB), .i_rqa(rqaB), .o_rqa_rd(rdB),
      .o_mem_idx(idxB), .i_mem_data(dataB), .i_mem_stat(statB), .i_rss_rdy(rssRdyB),
      .i_rsd_rdy(rsdRdyB), .o_rss(rssB), .o_rss_wr(rssWrB), .o_rsd(rsdB), .o_rsd_wr(rsdWrB),
      .o_nresp(nrespB), .o_idle(idleB)
`ifdef VXE_TGEN_ERR_INJ_EN
      , .i_err_n(8'd0), .i_err_code(9'd0)
`endif
   );

   // Show-ahead request FIFO model: a pop at the edge consumes one pending request.
   always @(posedge clk) begin
      if (rdA) begin
         pendA--;
         accA++;
      end
      if (rdB) begin
         pendB--;
         accB++;
      end
   end

   // Response FIFO model for instance A: record every word that transfers at the coming edge.
   always @(negedge clk) begin
      if (rssWrA && rssRdyA && rsdRdyA) begin
         gotA.push_back({rssA, rsdA});
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int n);
      pendA += n;
   endtask

   task automatic waitRespA(input int n, input int budget, input string name);
      int cnt = 0;
      while (gotA.size() < n && cnt < budget) begin
         step(1);
         cnt++;
      end
      checkOutput(name, 128'(gotA.size()), 128'(n));
   endtask

   task automatic checkResponses(input string tag, input vec_t vecs [6], input int n);
      logic [72:0] got;
      for (int i = 0; i < n; i++) begin
         if (gotA.size() == 0) begin
            checkOutput($sformatf("%s_missing%0d", tag, i), 128'd0, 128'd1);
         end else begin
            got = gotA.pop_front();
            checkOutput($sformatf("%s_rss%0d", tag, i), 128'(got[72:64]), 128'(vecs[i].expRss));
            checkOutput($sformatf("%s_rsd%0d", tag, i), 128'(got[63:0]), 128'(vecs[i].expRsd));
         end
      end
   endtask

   initial begin
      vec_t flow6 [6];
      int   accStart, accB0, k, w;

      flowVec[0] = '{9'h001, 64'h0123_4567_89AB_CDEF, 9'h001, 64'h0123_4567_89AB_CDEF};
      flowVec[1] = '{9'h0A5, 64'hFFFF_FFFF_FFFF_FFFE, 9'h0A5, 64'hFFFF_FFFF_FFFF_FFFE};
      flowVec[2] = '{9'h100, 64'h0000_0000_0000_0000, 9'h100, 64'h0000_0000_0000_0000};
      flowVec[3] = '{9'h155, 64'hFFFF_FFFF_FFFF_FFFF, 9'h000, 64'h0000_0000_0000_0000};
      for (int i = 0; i < 6; i++) begin
         bpVec[i] = '{9'h040 + 9'(i), 64'hB0B0_0000_0000_0000 + 64'(i),
                      9'h040 + 9'(i), 64'hB0B0_0000_0000_0000 + 64'(i)};
      end
      for (int i = 0; i < 6; i++) begin
         flow6[i] = (i < 4) ? flowVec[i] : flowVec[0];
      end
      for (int i = 0; i < 256; i++) begin
         memStat[i] = 9'h0;
         memData[i] = 64'h0;
      end

      rst = 1'b1; clrA = 1'b0; clrB = 1'b0;
      rssRdyA = 1'b1; rsdRdyA = 1'b1; rssRdyB = 1'b1; rsdRdyB = 1'b1;
`ifdef VXE_TGEN_ERR_INJ_EN
      errN = 8'd0; errCode = 9'd0;
`endif
      pendA = 1;
      step(3);
      checkOutput("rst_rqa_rd", 128'(rdA), 128'd0);
      checkOutput("rst_rss_wr", 128'(rssWrA), 128'd0);
      checkOutput("rst_idle", 128'(idleA), 128'd1);
      checkOutput("rst_nresp", 128'(nrespA), 128'd0);
      checkOutput("rst_mem_idx", 128'(idxA), 128'd0);
      checkOutput("rst_idle_b", 128'(idleB), 128'd1);
      pendA = 0;
      rst = 1'b0;
      step(1);

      // Flow: image A,B,C,terminator; the terminator answers zero and parks the index.
      for (int i = 0; i < 4; i++) begin
         memStat[i] = flowVec[i].memStat;
         memData[i] = flowVec[i].memData;
      end
      applyStimulus(4);
      waitRespA(4, 40, "flow_count");
      checkResponses("flow", flow6, 4);
      step(2);
      checkOutput("flow_mem_idx", 128'(idxA), 128'd3);
      checkOutput("flow_nresp", 128'(nrespA), 128'd4);
      checkOutput("flow_idle", 128'(idleA), 128'd1);

      // Soft clear with three requests outstanding (one parked in the output slot).
      for (int i = 3; i < 6; i++) begin
         memStat[i] = 9'h030 + 9'(i);
         memData[i] = 64'h00C0 + 64'(i);
      end
      rssRdyA = 1'b0;
      applyStimulus(3);
      step(6);
      checkOutput("clr_pre_idle", 128'(idleA), 128'd0);
      clrA = 1'b1;
      step(1);
      clrA = 1'b0;
      checkOutput("clr_idle", 128'(idleA), 128'd1);
      checkOutput("clr_mem_idx", 128'(idxA), 128'd0);
      checkOutput("clr_rss_wr", 128'(rssWrA), 128'd0);
      checkOutput("clr_nresp", 128'(nrespA), 128'd0);
      checkOutput("clr_rss", 128'(rssA), 128'd0);
      rssRdyA = 1'b1;
      step(3);
      checkOutput("clr_no_resp", 128'(gotA.size()), 128'd0);

      // Backpressure: four requests fill the queue and one more waits in the output slot.
      for (int i = 0; i < 6; i++) begin
         memStat[i] = bpVec[i].memStat;
         memData[i] = bpVec[i].memData;
      end
      rssRdyA = 1'b0;
      accStart = accA;
      applyStimulus(6);
      step(10);
      checkOutput("bp_accepted", 128'(accA - accStart), 128'd5);
      checkOutput("bp_rqa_rd", 128'(rdA), 128'd0);
      checkOutput("bp_rss_wr", 128'(rssWrA), 128'd1);
      checkOutput("bp_rsd_wr", 128'(rsdWrA), 128'd1);
      checkOutput("bp_rss_held", 128'(rssA), 128'(bpVec[0].expRss));
      checkOutput("bp_rsd_held", 128'(rsdA), 128'(bpVec[0].expRsd));
      rssRdyA = 1'b1;
      waitRespA(6, 40, "bp_count");
      checkResponses("bp", bpVec, 6);
      step(2);
      checkOutput("bp_nresp", 128'(nrespA), 128'd6);
      checkOutput("bp_mem_idx", 128'(idxA), 128'd6);
      checkOutput("bp_idle", 128'(idleA), 128'd1);

`ifdef VXE_TGEN_ERR_INJ_EN
      // Every third launched response carries the injected code with zero data.
      clrA = 1'b1;
      step(1);
      clrA = 1'b0;
      errN = 8'd3;
      errCode = 9'h1FF;
      for (int i = 0; i < 6; i++) begin
         flow6[i] = bpVec[i];
         if (i % 3 == 2) begin
            flow6[i].expRss = 9'h1FF;
            flow6[i].expRsd = 64'h0;
         end
      end
      applyStimulus(6);
      waitRespA(6, 40, "err_count");
      checkResponses("err", flow6, 6);
      step(2);
      checkOutput("err_mem_idx", 128'(idxA), 128'd6);
      errN = 8'd0;
`endif

      // Latency 5 on a 3-bit timestamp: launch exactly six cycles after the accept, at every phase.
      for (int tr = 0; tr < 8; tr++) begin
         step(tr + 1);
         accB0 = accB;
         pendB = 1;
         w = 0;
         while (accB == accB0 && w < 10) begin
            step(1);
            w++;
         end
         checkOutput($sformatf("lat_accept%0d", tr), 128'(accB - accB0), 128'd1);
         k = 0;
         while (k < 12) begin
            @(negedge clk);
            k++;
            if (rssWrB) break;
         end
         checkOutput($sformatf("lat_first_wr%0d", tr), 128'(k), 128'd6);
      end
      step(3);
      checkOutput("lat_nresp", 128'(nrespB), 128'd8);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
